// File: rtl/time_pkg.sv
// Shared widths, limits and helpers for the time_keeper datapath.
package time_pkg;

    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;
    localparam int DAY_W    = 3;

    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int DAY_MAX  = 6;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
    } hm_t;

    // 24h hour to 12h clock-face hour: 0 -> 12, 13..23 -> 1..11.
    function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
        if (h == '0)
            return HOUR_W'(12);
        else if (h > HOUR_W'(12))
            return h - HOUR_W'(12);
        else
            return h;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with synchronous load (priority over inc) and a
// combinational carry that fires on the increment that wraps to zero.
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         carry
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        carry   = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            if (count_q == W'(MOD - 1)) begin
                count_d = '0;
                carry   = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/time_keeper.sv
// Running day/hour/minute clock with edit and alarm registers, 12/24h
// display conversion and a registered alarm-match pulse with latched Ring.
module time_keeper
    import time_pkg::*;
#(
    parameter int SEC_PER_MIN = 60
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Tick,
    input  logic              IM,
    input  logic              IH,
    input  logic              ID,
    input  logic              LD_TIME,
    input  logic              LD_R,
    input  logic              TOF,
    input  logic              AlarmEn,
    input  logic              Dismiss,
    output logic [MIN_W-1:0]  Min,
    output logic [HOUR_W-1:0] Hour,
    output logic [DAY_W-1:0]  Day,
    output logic [MIN_W-1:0]  EditMin,
    output logic [HOUR_W-1:0] EditHour,
    output logic [DAY_W-1:0]  EditDay,
    output logic [MIN_W-1:0]  AlarmMin,
    output logic [HOUR_W-1:0] AlarmHour,
    output logic [HOUR_W-1:0] DispHour,
    output logic              PM,
    output logic              Fmt12,
    output logic              Match,
    output logic              Ring
);

    localparam int SEC_W = $clog2(SEC_PER_MIN);

    logic [SEC_W-1:0] sec;
    logic             sec_carry;
    logic             min_carry;
    logic             hour_carry;
    logic [3:0]       unused_carry;

    // LD_TIME loads every running counter, which also suppresses any
    // carry (and therefore drops a coincident Tick).
    mod_counter #(.MOD(SEC_PER_MIN), .W(SEC_W)) u_sec (
        .clk(Clk), .srst(Rst), .inc(Tick), .load(LD_TIME),
        .load_val('0), .count(sec), .carry(sec_carry)
    );
    mod_counter #(.MOD(MIN_MAX + 1), .W(MIN_W)) u_min (
        .clk(Clk), .srst(Rst), .inc(sec_carry), .load(LD_TIME),
        .load_val(EditMin), .count(Min), .carry(min_carry)
    );
    mod_counter #(.MOD(HOUR_MAX + 1), .W(HOUR_W)) u_hour (
        .clk(Clk), .srst(Rst), .inc(min_carry), .load(LD_TIME),
        .load_val(EditHour), .count(Hour), .carry(hour_carry)
    );
    mod_counter #(.MOD(DAY_MAX + 1), .W(DAY_W)) u_day (
        .clk(Clk), .srst(Rst), .inc(hour_carry), .load(LD_TIME),
        .load_val(EditDay), .count(Day), .carry(unused_carry[0])
    );

    // Edit fields wrap independently; commits read the pre-increment value.
    mod_counter #(.MOD(MIN_MAX + 1), .W(MIN_W)) u_edit_min (
        .clk(Clk), .srst(Rst), .inc(IM), .load(1'b0),
        .load_val('0), .count(EditMin), .carry(unused_carry[1])
    );
    mod_counter #(.MOD(HOUR_MAX + 1), .W(HOUR_W)) u_edit_hour (
        .clk(Clk), .srst(Rst), .inc(IH), .load(1'b0),
        .load_val('0), .count(EditHour), .carry(unused_carry[2])
    );
    mod_counter #(.MOD(DAY_MAX + 1), .W(DAY_W)) u_edit_day (
        .clk(Clk), .srst(Rst), .inc(ID), .load(1'b0),
        .load_val('0), .count(EditDay), .carry(unused_carry[3])
    );

    hm_t  alarm_q, alarm_d;
    logic fmt12_q, fmt12_d;
    logic min_event_q, min_event_d;
    logic match_q, match_d;
    logic ring_q, ring_d;

    always_comb begin
        alarm_d     = alarm_q;
        fmt12_d     = fmt12_q ^ TOF;
        min_event_d = sec_carry | LD_TIME;
        if (LD_R) begin
            alarm_d.hour = EditHour;
            alarm_d.min  = EditMin;
        end
        // Compare only on the cycle after the running time just changed,
        // so a static time or an LD_R onto the current time never fires.
        match_d = AlarmEn && min_event_q &&
                  (Hour == alarm_q.hour) && (Min == alarm_q.min);
        ring_d  = ring_q | match_d;
        if (Dismiss || !AlarmEn)
            ring_d = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            alarm_q     <= '0;
            fmt12_q     <= 1'b0;
            min_event_q <= 1'b0;
            match_q     <= 1'b0;
            ring_q      <= 1'b0;
        end else begin
            alarm_q     <= alarm_d;
            fmt12_q     <= fmt12_d;
            min_event_q <= min_event_d;
            match_q     <= match_d;
            ring_q      <= ring_d;
        end
    end

    assign AlarmMin  = alarm_q.min;
    assign AlarmHour = alarm_q.hour;
    assign Fmt12     = fmt12_q;
    assign Match     = match_q;
    assign Ring      = ring_q;
    assign DispHour  = fmt12_q ? to_12h(Hour) : Hour;
    assign PM        = fmt12_q && (Hour >= HOUR_W'(12));

endmodule
